// File: rtl/uart_word_rx_pkg.sv
// Shared definitions for the framed UART word receiver: state encodings and defaults.
// ST_CHECK is only present when UART_WORD_CHECKSUM_EN is defined.
package uart_word_rx_pkg;

    localparam int         DEF_CLKS_PER_BIT = 868;
    localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef UART_WORD_CHECKSUM_EN
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
`else
        ST_PAYLOAD = 2'd1
`endif
    } word_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// Bit-level 8N1 receiver: synchronizes the line, samples mid-bit and strobes
// each received byte (good stop bit) or a stop error (low stop bit) for one cycle.
module uart_rx_core
    import uart_word_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_stop_err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             w_rx;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_half;
    logic             w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= 1'b1;
            r_sync_p1 <= 1'b1;
        end else begin
            r_sync_p0 <= i_rx_serial;
            r_sync_p1 <= r_sync_p0;
        end
    end

    assign w_rx   = r_sync_p1;
    assign w_half = (r_cnt == CNT_W'((CLKS_PER_BIT - 1) / 2));
    assign w_full = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign o_byte = r_shift;

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_nxt;
    end

    // After a low stop bit the line may still be low; wait for idle before re-arming.
    always_comb begin
        w_state_nxt = r_state;
        o_byte_vld  = 1'b0;
        o_stop_err  = 1'b0;
        case (r_state)
            RX_IDLE:  if (!w_rx) w_state_nxt = RX_START;
            RX_START: if (w_half) w_state_nxt = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_full && (r_bit == 3'd7)) w_state_nxt = RX_STOP;
            RX_STOP: begin
                if (w_full) begin
                    if (w_rx) begin
                        o_byte_vld  = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        o_stop_err  = 1'b1;
                        w_state_nxt = RX_WAIT;
                    end
                end
            end
            RX_WAIT:  if (w_rx) w_state_nxt = RX_IDLE;
            default:  w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                RX_START:         r_cnt <= w_half ? '0 : r_cnt + 1'b1;
                RX_DATA, RX_STOP: r_cnt <= w_full ? '0 : r_cnt + 1'b1;
                default:          r_cnt <= '0;
            endcase
            if (r_state == RX_IDLE) begin
                r_bit <= '0;
            end else if ((r_state == RX_DATA) && w_full) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_word_rx.sv
// Framed UART word receiver: SYNC_BYTE header followed by NBYTES payload bytes.
// Define UART_WORD_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_word_rx
    import uart_word_rx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int         NBYTES       = 2,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_serial,
    output logic [8*NBYTES-1:0] data,
    output logic                data_valid,
    output logic                frame_err,
    output logic                busy
);
    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES + 1);
    localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);

    logic [7:0]       w_byte;
    logic             w_byte_vld;
    logic             w_stop_err;
    word_state_t      r_state;
    word_state_t      w_state_nxt;
    logic [W-1:0]     r_data;
    logic [W-1:0]     r_shadow;
    logic [W-1:0]     w_shadow_nxt;
    logic [W-1:0]     w_word;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             w_last;
    logic             w_timeout;
    logic             w_start;
    logic             w_shift;
    logic             w_load;
    logic             w_err;
`ifdef UART_WORD_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk         (clk),
        .rst         (rst),
        .i_rx_serial (rx_serial),
        .o_byte      (w_byte),
        .o_byte_vld  (w_byte_vld),
        .o_stop_err  (w_stop_err)
    );

    // First byte received ends up in the MSBs.
    assign w_shadow_nxt = (r_shadow << 8) | W'(w_byte);
    assign w_last       = (r_idx == IDX_W'(NBYTES - 1));
    assign w_timeout    = (r_state != ST_IDLE) && (r_gap == GAP_W'(TIMEOUT_CLKS - 1));
`ifdef UART_WORD_CHECKSUM_EN
    assign w_word       = r_shadow;
`else
    assign w_word       = w_shadow_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_load      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_vld && (w_byte == SYNC_BYTE)) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (w_byte_vld) begin
                    w_shift = 1'b1;
                    if (w_last) begin
`ifdef UART_WORD_CHECKSUM_EN
                        w_state_nxt = ST_CHECK;
`else
                        w_load      = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end else if (w_stop_err || w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef UART_WORD_CHECKSUM_EN
            ST_CHECK: begin
                if (w_byte_vld) begin
                    w_load      = (w_byte == r_csum);
                    w_err       = (w_byte != r_csum);
                    w_state_nxt = ST_IDLE;
                end else if (w_stop_err || w_timeout) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_shadow     <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_WORD_CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_data_valid <= w_load;
            r_frame_err  <= w_err;
            if (w_load) r_data <= w_word;
            if (w_start) begin
                r_shadow <= '0;
                r_idx    <= '0;
`ifdef UART_WORD_CHECKSUM_EN
                r_csum   <= '0;
`endif
            end else if (w_shift) begin
                r_shadow <= w_shadow_nxt;
                r_idx    <= r_idx + 1'b1;
`ifdef UART_WORD_CHECKSUM_EN
                r_csum   <= r_csum ^ w_byte;
`endif
            end
            // Gap timer measures idle time since the last good byte inside a frame.
            if ((r_state == ST_IDLE) || w_byte_vld) r_gap <= '0;
            else                                    r_gap <= r_gap + 1'b1;
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_word_rx.sv
// Bench for uart_word_rx: directed frames plus random byte streams checked
// against a byte-level frame model.
module tb_uart_word_rx;
    localparam int         CPB  = 16;
    localparam int         NB   = 2;
    localparam int         TMO  = 640;
    localparam logic [7:0] SYNC = 8'hA5;

    logic            clk = 1'b0;
    logic            rst;
    logic            rx_serial;
    logic [8*NB-1:0] data;
    logic            data_valid;
    logic            frame_err;
    logic            busy;

    int n_checks  = 0;
    int n_pass    = 0;
    int dv_seen   = 0;
    int fe_seen   = 0;
    int both_seen = 0;

    int              exp_dv   = 0;
    int              exp_fe   = 0;
    logic [8*NB-1:0] exp_data = '0;
    bit              in_frame = 1'b0;
    logic [7:0]      pl_q[$];

    uart_word_rx #(
        .CLKS_PER_BIT (CPB),
        .NBYTES       (NB),
        .SYNC_BYTE    (SYNC),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_serial  (rx_serial),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) dv_seen++;
        if (frame_err === 1'b1) fe_seen++;
        if ((data_valid === 1'b1) && (frame_err === 1'b1)) both_seen++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [8*NB-1:0] pack_q();
        logic [8*NB-1:0] v = '0;
        foreach (pl_q[i]) v = (v << 8) | {{(8*NB-8){1'b0}}, pl_q[i]};
        return v;
    endfunction

    // Frame-level reference: header, payload, optional XOR byte.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [7:0] x;
        if (!ok) begin
            if (in_frame) begin exp_fe++; in_frame = 1'b0; end
            return;
        end
        if (!in_frame) begin
            if (b == SYNC) begin in_frame = 1'b1; pl_q.delete(); end
            return;
        end
        if (pl_q.size() < NB) begin
            pl_q.push_back(b);
`ifndef UART_WORD_CHECKSUM_EN
            if (pl_q.size() == NB) begin
                exp_data = pack_q(); exp_dv++; in_frame = 1'b0;
            end
`endif
        end else begin
            x = 8'h00;
            foreach (pl_q[i]) x ^= pl_q[i];
            if (x == b) begin exp_data = pack_q(); exp_dv++; end
            else exp_fe++;
            in_frame = 1'b0;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit ok);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = ok;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic xfer(input logic [7:0] b, input bit ok, input int gap);
        drive_byte(b, ok);
        model_byte(b, ok);
        repeat (gap) @(negedge clk);
        if ((gap >= TMO) && in_frame) begin exp_fe++; in_frame = 1'b0; end
        check("dv_count", dv_seen, exp_dv);
        check("fe_count", fe_seen, exp_fe);
        check("data", data, exp_data);
        check("busy", busy, in_frame);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dv_out", data_valid, 0);
        check("rst_fe_out", frame_err, 0);
        @(negedge clk);
        rst = 1'b0;
        in_frame = 1'b0;
        exp_data = '0;
        pl_q.delete();
        repeat (2) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_busy", busy, 0);
        check("rst_dv_count", dv_seen, exp_dv);
        check("rst_fe_count", fe_seen, exp_fe);
    endtask

    initial begin
        logic [7:0] b;
        bit         ok;
        int         gap;
        int         fe0;
        int         dv0;
        rst = 1'b1;
        rx_serial = 1'b1;
        do_reset();

        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 8); xfer(8'h34, 1, 8);
`ifndef UART_WORD_CHECKSUM_EN
        check("r029_data", data, 16'h1234);
        check("r029_dv", dv_seen, 1);
        check("r029_busy", busy, 0);
`endif
        xfer(8'h00, 1, 8); xfer(8'h12, 1, 8); xfer(8'hA5, 1, 8);
        xfer(8'hA5, 1, 8); xfer(8'h56, 1, 8);
`ifndef UART_WORD_CHECKSUM_EN
        check("r030_data", data, 16'hA556);
        check("r030_dv", dv_seen, 2);
`endif
        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 700);
`ifndef UART_WORD_CHECKSUM_EN
        check("r031_fe", fe_seen, 1);
        check("r031_hold", data, 16'hA556);
`endif
        xfer(8'hA5, 1, 8); xfer(8'hAB, 1, 8); xfer(8'hCD, 1, 8);
`ifndef UART_WORD_CHECKSUM_EN
        check("r031_data", data, 16'hABCD);
`endif
        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 8); xfer(8'h5A, 0, 8);
`ifndef UART_WORD_CHECKSUM_EN
        check("r032_fe", fe_seen, 2);
        check("r032_hold", data, 16'hABCD);
`endif
        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 8);
        do_reset();
        xfer(8'hA5, 1, 8); xfer(8'h77, 1, 8); xfer(8'h88, 1, 8);
`ifndef UART_WORD_CHECKSUM_EN
        check("r033_data", data, 16'h7788);
        check("r033_fe", fe_seen, 2);
`endif

`ifdef UART_WORD_CHECKSUM_EN
        do_reset();
        dv0 = dv_seen;
        fe0 = fe_seen;
        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 8); xfer(8'h34, 1, 8); xfer(8'h26, 1, 8);
        check("r034_data", data, 16'h1234);
        check("r034_dv", dv_seen - dv0, 1);
        xfer(8'hA5, 1, 8); xfer(8'h12, 1, 8); xfer(8'h34, 1, 8); xfer(8'h27, 1, 8);
        check("r034_fe", fe_seen - fe0, 1);
        check("r034_hold", data, 16'h1234);
`else
        dv0 = 0;
        fe0 = 0;
`endif

        for (int k = 0; k < 120; k++) begin
            b   = ($urandom_range(0, 99) < 30) ? SYNC : 8'($urandom);
            ok  = ($urandom_range(0, 19) != 0);
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(700, 800))
                                              : int'($urandom_range(4, 40));
            xfer(b, ok, gap);
        end

        check("dv_fe_overlap", both_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clk cycles per UART bit (100 MHz / 115200).
REQ-002 SHALL have parameter NBYTES, default 2, giving payload bytes per frame (legal 1..8).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame header value.
REQ-004 SHALL have parameter TIMEOUT_CLKS, default 10*CLKS_PER_BIT*4, giving the maximum idle gap between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, reset: synchronous, active-high, clock clk.
REQ-007 SHALL have port rx_serial, input, 1, asynchronous UART line, idle high, 8N1, LSB first.
REQ-008 SHALL have port data, output, 8*NBYTES, last accepted payload; first received byte in the MSBs.
REQ-009 SHALL have port data_valid, output, 1, one-cycle pulse when data updates.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse when a frame is abandoned.
REQ-011 SHALL have port busy, output, 1, high while the FSM is not IDLE.

Function
REQ-012 SHALL pass rx_serial through a 2-FF synchronizer before any use.
REQ-013 SHALL validate the start bit at mid-bit, sample data bits at mid-bit and check the stop bit; a false start returns to line idle with no byte strobe.
REQ-014 SHALL emit a byte strobe on a good stop bit and a stop-error strobe on a low stop bit, each for one cycle.
REQ-015 SHALL implement FSM states IDLE, PAYLOAD and CHECK; CHECK exists only with the checksum macro defined.
REQ-016 In IDLE, a byte equal to SYNC_BYTE SHALL go to PAYLOAD and clear the byte index, shadow register and checksum; any other byte is discarded silently.
REQ-017 In PAYLOAD, each byte SHALL shift into the shadow register and the index SHALL increment; SYNC_BYTE values in the payload are data.
REQ-018 On byte NBYTES-1 without the checksum macro, data SHALL load the assembled word and data_valid SHALL pulse on the same edge, and the FSM SHALL return to IDLE.
REQ-019 While not IDLE, a gap counter SHALL clear on every byte strobe; on reaching TIMEOUT_CLKS it SHALL pulse frame_err, return to IDLE and leave data unchanged.
REQ-020 A stop-error strobe while not IDLE SHALL pulse frame_err and return to IDLE; in IDLE it SHALL be ignored.
REQ-021 data SHALL hold its value between valid frames; data_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-022 Reset SHALL force IDLE, data=0, data_valid=0, frame_err=0, busy=0, clear all counters and the shadow register, and set the synchronizer to 1.
REQ-023 Reset mid-frame SHALL discard the partial frame with no pulse; reception SHALL restart with the next start bit after rst deasserts.

Configuration
REQ-024 With UART_WORD_CHECKSUM_EN defined, the byte after the payload SHALL be compared in CHECK against the XOR of all payload bytes.
REQ-025 On a checksum match, data SHALL load and data_valid SHALL pulse; on a mismatch, frame_err SHALL pulse and data SHALL stay unchanged; both cases return to IDLE.
REQ-026 With UART_WORD_CHECKSUM_EN undefined, the CHECK state and checksum logic SHALL be absent and behaviour SHALL follow REQ-018.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, the default SYNC_BYTE and the default CLKS_PER_BIT.
REQ-028 The bit-level receiver (REQ-012 to REQ-014) SHALL be the sub-module uart_rx_core; framing logic stays in uart_word_rx.

Verification
The bench uses CLKS_PER_BIT=16, NBYTES=2 and TIMEOUT_CLKS=640.
REQ-029 Bytes A5,12,34 -> data=16'h1234, one data_valid pulse, busy low afterwards.
REQ-030 Bytes 00,12,A5,A5,56 -> 00 and 12 ignored, then data=16'hA556.
REQ-031 Bytes A5,12, then idle 700 clks, then A5,AB,CD -> one frame_err pulse, data stays, then data=16'hABCD.
REQ-032 Bytes A5,12 with a low stop bit on the next byte -> frame_err pulse, data unchanged.
REQ-033 rst asserted after A5,12, then bytes A5,77,88 -> no pulse at reset, data=0, then data=16'h7788.
REQ-034 With UART_WORD_CHECKSUM_EN, bytes A5,12,34,26 -> data=16'h1234; bytes A5,12,34,27 -> frame_err, data unchanged.
